// File: rtl/multi_byte_add_sequencer_module_pkg.sv
// Shared constants for the byte-serial wide adder: FSM encoding and sizing.
package multi_byte_add_sequencer_module_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int NUM_BYTES_DEF = 4;
  // Wide enough to index up to 8 byte slices.
  localparam int IDX_W = 3;
endpackage

// File: rtl/multi_byte_add_sequencer_module_adder.sv
// 8-bit ripple adder slice: {cout,sum} = a + b + cin.
module eight_bit_full_adder_module (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

// File: rtl/multi_byte_add_sequencer_module.sv
// Byte-serial W-bit add/subtract: one 8-bit slice per clock, LSB first,
// with the inter-byte carry held in a register.
module multi_byte_add_sequencer_module
  import multi_byte_add_sequencer_module_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   cout,
  output logic                   ovf
);
  localparam int W = 8 * NUM_BYTES;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

  logic [1:0]                  state;
  logic [IDX_W-1:0]            idx;
  logic                        carry;
  logic [W-1:0]                a_reg, b_reg;
  logic [NUM_BYTES-1:0][7:0]   shadow, res_next;
  logic [7:0]                  a_byte, b_byte, sum;
  logic                        add_cout;

  assign a_byte = 8'(a_reg >> {idx, 3'b000});
  assign b_byte = 8'(b_reg >> {idx, 3'b000});

  eight_bit_full_adder_module u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (sum),
    .cout (add_cout)
  );

  // Final word = stored lower slices plus the top slice still on the adder.
  always_comb begin
    res_next = shadow;
    res_next[NUM_BYTES-1] = sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      shadow <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          for (int i = 0; i < NUM_BYTES; i++)
            if (idx == IDX_W'(i)) shadow[i] <= sum;
          carry <= add_cout;
          if (idx == LAST) begin
            state  <= DONE;
            result <= res_next;
            cout   <= add_cout;
            // b_reg already holds the inverted operand for subtraction.
            ovf    <= (a_reg[W-1] == b_reg[W-1]) && (sum[7] != a_reg[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule
